ysyx_23060191_wbu: RTL and testbench

//  Write-back unit: the driving end of the GPR write port (wr_en_Rd/addr_Rd/data_Rd).

---
 rtl/ysyx_23060191_wbu_if.sv | 33 +++
 rtl/ysyx_23060191_wbu.sv | 134 +++++++++++++
 tb/tb_ysyx_23060191_wbu.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060191_wbu_if.sv
// Retire-side bundle of the write-back unit: EXU/LSU handshake, load response and GPR write port.
// master = upstream pipeline / memory side, slave = the write-back unit.
interface ysyx_23060191_wbu_if #(
    parameter int unsigned CPU_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [CPU_WIDTH-1:0] in_result;
    logic [4:0]           in_rd;
    logic                 in_rd_wen;
    logic                 in_is_load;
    logic [2:0]           in_funct3;
    logic [1:0]           in_offset;
    logic                 mem_rvalid;
    logic [CPU_WIDTH-1:0] mem_rdata;
    logic                 gpr_wr_en;
    logic [4:0]           gpr_addr_rd;
    logic [CPU_WIDTH-1:0] gpr_data_rd;
    logic                 commit;
    logic                 err;

    modport master (
        output in_valid, in_result, in_rd, in_rd_wen, in_is_load, in_funct3, in_offset,
        output mem_rvalid, mem_rdata,
        input  in_ready, gpr_wr_en, gpr_addr_rd, gpr_data_rd, commit, err
    );

    modport slave (
        input  in_valid, in_result, in_rd, in_rd_wen, in_is_load, in_funct3, in_offset,
        input  mem_rvalid, mem_rdata,
        output in_ready, gpr_wr_en, gpr_addr_rd, gpr_data_rd, commit, err
    );
endinterface

// File: rtl/ysyx_23060191_wbu.sv
// Write-back unit: accepts one retiring instruction, waits for load data when needed, then
// issues a single registered GPR write plus a one-cycle commit pulse.
module ysyx_23060191_wbu #(
    parameter int unsigned CPU_WIDTH    = 32,
    parameter int unsigned LOAD_TIMEOUT = 255
) (
    input logic                clk,
    input logic                rst_n,
    ysyx_23060191_wbu_if.slave bus
);
    localparam int unsigned CntW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StWaitMem, StWrite} state_e;

    state_e               state_q, state_d;
    logic [4:0]           rd_q, rd_d;
    logic                 rd_wen_q, rd_wen_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [1:0]           offset_q, offset_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 gpr_wr_en_q, gpr_wr_en_d;
    logic [4:0]           gpr_addr_q, gpr_addr_d;
    logic [CPU_WIDTH-1:0] gpr_data_q, gpr_data_d;
    logic                 commit_q, commit_d;
    logic                 err_q, err_d;

    function automatic logic [CPU_WIDTH-1:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                                     input logic [CPU_WIDTH-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = w[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  return {{(CPU_WIDTH-8){b[7]}}, b};
            3'b001:  return {{(CPU_WIDTH-16){h[15]}}, h};
            3'b100:  return {{(CPU_WIDTH-8){1'b0}}, b};
            3'b101:  return {{(CPU_WIDTH-16){1'b0}}, h};
            default: return w;  // LW and the illegal encodings
        endcase
    endfunction

    function automatic logic illegal_f3(input logic [2:0] f3);
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    always_comb begin
        state_d     = state_q;
        rd_d        = rd_q;
        rd_wen_d    = rd_wen_q;
        funct3_d    = funct3_q;
        offset_d    = offset_q;
        cnt_d       = cnt_q;
        gpr_wr_en_d = 1'b0;
        gpr_addr_d  = gpr_addr_q;
        gpr_data_d  = gpr_data_q;
        commit_d    = 1'b0;
        err_d       = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    rd_d     = bus.in_rd;
                    rd_wen_d = bus.in_rd_wen;
                    funct3_d = bus.in_funct3;
                    offset_d = bus.in_offset;
                    if (bus.in_is_load) begin
                        cnt_d   = '0;
                        state_d = StWaitMem;
                    end else begin
                        gpr_wr_en_d = bus.in_rd_wen && (bus.in_rd != 5'd0);
                        gpr_addr_d  = bus.in_rd;
                        gpr_data_d  = bus.in_result;
                        commit_d    = 1'b1;
                        state_d     = StWrite;
                    end
                end
            end
            StWaitMem: begin
                // Data arriving on the timeout cycle still wins over the abort.
                if (bus.mem_rvalid || (cnt_q == CntW'(LOAD_TIMEOUT - 1))) begin
                    gpr_wr_en_d = rd_wen_q && (rd_q != 5'd0);
                    gpr_addr_d  = rd_q;
                    commit_d    = 1'b1;
                    state_d     = StWrite;
                    if (bus.mem_rvalid) begin
                        gpr_data_d = load_ext(funct3_q, offset_q, bus.mem_rdata);
                        err_d      = err_q | illegal_f3(funct3_q);
                    end else begin
                        gpr_data_d = '0;
                        err_d      = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWrite: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            rd_q        <= '0;
            rd_wen_q    <= 1'b0;
            funct3_q    <= '0;
            offset_q    <= '0;
            cnt_q       <= '0;
            gpr_wr_en_q <= 1'b0;
            gpr_addr_q  <= '0;
            gpr_data_q  <= '0;
            commit_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_q        <= rd_d;
            rd_wen_q    <= rd_wen_d;
            funct3_q    <= funct3_d;
            offset_q    <= offset_d;
            cnt_q       <= cnt_d;
            gpr_wr_en_q <= gpr_wr_en_d;
            gpr_addr_q  <= gpr_addr_d;
            gpr_data_q  <= gpr_data_d;
            commit_q    <= commit_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready    = (state_q == StIdle) && rst_n;
    assign bus.gpr_wr_en   = gpr_wr_en_q;
    assign bus.gpr_addr_rd = gpr_addr_q;
    assign bus.gpr_data_rd = gpr_data_q;
    assign bus.commit      = commit_q;
    assign bus.err         = err_q;
endmodule

// File: tb/tb_ysyx_23060191_wbu.sv
// Scoreboard bench for the write-back unit: the driver pushes the expected write per instruction,
// a negedge monitor pops and compares on every commit pulse.
module tb_ysyx_23060191_wbu;
    localparam int unsigned W = 32;
    localparam int unsigned T = 4;

    typedef struct packed {
        logic        wen;
        logic [4:0]  addr;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t exp_q[$];
    exp_t mon_e;
    logic err_model;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ysyx_23060191_wbu_if #(.CPU_WIDTH(W)) bus ();

    ysyx_23060191_wbu #(.CPU_WIDTH(W), .LOAD_TIMEOUT(T)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Load result computed from the ISA rules with plain shifts and two's-complement arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] v;
        case (f3)
            3'b000: begin
                v = (w >> (8 * int'(off))) & 32'hFF;
                if (v >= 32'h80) v = v - 32'h100;
            end
            3'b001: begin
                v = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
                if (v >= 32'h8000) v = v - 32'h1_0000;
            end
            3'b100:  v = (w >> (8 * int'(off))) & 32'hFF;
            3'b101:  v = (w >> (16 * (int'(off) / 2))) & 32'hFFFF;
            default: v = w;
        endcase
        return v;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.commit) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_commit: commit=1 with nothing pending, expected 0");
                end else begin
                    mon_e = exp_q.pop_front();
                    check("gpr_wr_en", bus.gpr_wr_en, mon_e.wen);
                    if (mon_e.wen) begin
                        check("gpr_addr_rd", bus.gpr_addr_rd, mon_e.addr);
                        check("gpr_data_rd", bus.gpr_data_rd, mon_e.data);
                    end
                    check("err", bus.err, mon_e.err);
                    check("in_ready_in_write", bus.in_ready, 1'b0);
                end
            end else if (bus.gpr_wr_en) begin
                checks++;
                errors++;
                $display("FAIL stray_write: gpr_wr_en=1 without commit, expected 0");
            end
        end
    end

    // Present one instruction and wait (bounded) for the transfer; returns at #1 after that edge.
    task automatic accept(input logic ld, input logic [4:0] rd, input logic wen,
                          input logic [2:0] f3, input logic [1:0] off, input logic [31:0] res,
                          output logic ok);
        int   n;
        logic rdy;
        bus.in_valid   = 1'b1;
        bus.in_is_load = ld;
        bus.in_rd      = rd;
        bus.in_rd_wen  = wen;
        bus.in_funct3  = f3;
        bus.in_offset  = off;
        bus.in_result  = res;
        n = 0;
        do begin
            @(negedge clk);
            rdy = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!rdy && n < 20);
        bus.in_valid = 1'b0;
        ok = rdy;
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready=0 for %0d cycles, expected 1", n);
        end
    endtask

    // k = cycle after acceptance that carries mem_rvalid (0 = none).
    task automatic issue(input logic ld, input logic [4:0] rd, input logic wen,
                         input logic [2:0] f3, input logic [1:0] off, input logic [31:0] res,
                         input logic [31:0] rdata, input int k);
        exp_t e;
        logic ok;
        accept(ld, rd, wen, f3, off, res, ok);
        if (!ok) return;
        e.wen  = wen && (rd != 5'd0);
        e.addr = rd;
        if (!ld) begin
            e.data = res;
        end else if (k <= int'(T)) begin
            e.data = ref_load(f3, off, rdata);
            if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) err_model = 1'b1;
        end else begin
            e.data    = 32'h0;
            err_model = 1'b1;
        end
        e.err = err_model;
        exp_q.push_back(e);
        if (k > 0) begin
            repeat (k - 1) begin
                @(posedge clk);
                #1;
            end
            bus.mem_rvalid = 1'b1;
            bus.mem_rdata  = rdata;
            @(posedge clk);
            #1;
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = $urandom;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ok;
        logic        ld;
        logic        wen;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [1:0]  off;
        int          k;
        rst_n          = 1'b0;
        err_model      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_is_load = 1'b0;
        bus.in_rd      = '0;
        bus.in_rd_wen  = 1'b0;
        bus.in_funct3  = '0;
        bus.in_offset  = '0;
        bus.in_result  = '0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
        #12;
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_gpr_wr_en", bus.gpr_wr_en, 1'b0);
        check("rst_commit", bus.commit, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_gpr_addr", bus.gpr_addr_rd, 5'd0);
        check("rst_gpr_data", bus.gpr_data_rd, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;

        issue(1'b0, 5'd5, 1'b1, 3'b000, 2'd0, 32'h1234_5678, 32'h0, 0);
        issue(1'b1, 5'd7, 1'b1, 3'b000, 2'd3, 32'h0, 32'h80FF_0000, 4);
        issue(1'b1, 5'd8, 1'b1, 3'b101, 2'd2, 32'h0, 32'hBEEF_1234, 2);
        issue(1'b1, 5'd8, 1'b1, 3'b001, 2'd3, 32'h0, 32'hBEEF_1234, 1);
        issue(1'b0, 5'd0, 1'b1, 3'b000, 2'd0, 32'hDEAD_BEEF, 32'h0, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rd0_in_ready_after", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;

        issue(1'b1, 5'd9, 1'b1, 3'b010, 2'd0, 32'h0, 32'h5555_AAAA, T + 2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("err_sticky", bus.err, 1'b1);
        @(posedge clk);
        #1;

        // Abandon a load in WAIT_MEM by reset; its late data must not retire anything.
        accept(1'b1, 5'd3, 1'b1, 3'b010, 2'd0, 32'h0, ok);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        err_model = 1'b0;
        #3;
        check("midload_rst_in_ready", bus.in_ready, 1'b0);
        check("midload_rst_commit", bus.commit, 1'b0);
        check("midload_rst_err", bus.err, 1'b0);
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        bus.mem_rvalid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("post_rst_in_ready", bus.in_ready, 1'b1);
        check("post_rst_gpr_data", bus.gpr_data_rd, 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 150; i++) begin
            ld  = 1'($urandom_range(0, 1));
            rd  = 5'($urandom_range(0, 31));
            wen = ($urandom_range(0, 3) != 0);
            f3  = 3'($urandom_range(0, 7));
            off = 2'($urandom_range(0, 3));
            k   = ld ? int'($urandom_range(1, T + 2)) : int'($urandom_range(0, 2));
            issue(ld, rd, wen, f3, off, $urandom, $urandom, k);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
